// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, serial in/out at both ends and
// four shift/rotate modes. A multi-position shift runs under a small FSM with
// a busy/done handshake.
// Optional build macro: ARITH_SHIFT_EN turns mode 01 into an arithmetic right
// shift (the MSB refills itself and sInL is ignored). Without it, mode 01 is a
// logical right shift filled from sInL.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             load,
  input  logic [WIDTH-1:0] dIn,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] shAmt,
  input  logic             sInL,
  input  logic             sInR,
  output logic [WIDTH-1:0] dOut,
  output logic             sOutL,
  output logic             sOutR,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       modeLat;
  logic [CNT_W-1:0] startCnt;
  logic             fillMsb;
  logic [WIDTH-1:0] shifted;

  // Serial outputs are plain taps of the register ends.
  assign sOutL = dOut[WIDTH-1];
  assign sOutR = dOut[0];

  // Shift amounts beyond the register width clamp to a full-width operation.
  always_comb begin
    startCnt = shAmt;
    if (shAmt > MAX_CNT) begin
      startCnt = MAX_CNT;
    end
  end

  // Bit that enters at the MSB on a right shift (sign copy or serial input).
  always_comb begin
`ifdef ARITH_SHIFT_EN
    fillMsb = dOut[WIDTH-1];
`else
    fillMsb = sInL;
`endif
  end

  // One-position step using the mode latched at start; serial fills are live.
  always_comb begin
    shifted = dOut;
    case (modeLat)
      MODE_SHL: shifted = {dOut[WIDTH-2:0], sInR};
      MODE_SHR: shifted = {fillMsb, dOut[WIDTH-1:1]};
      MODE_ROL: shifted = {dOut[WIDTH-2:0], dOut[WIDTH-1]};
      MODE_ROR: shifted = {dOut[0], dOut[WIDTH-1:1]};
      default:  shifted = dOut;
    endcase
  end

  // Control FSM and datapath register; busy/done are registered with the state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      dOut    <= '0;
      count   <= '0;
      modeLat <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            dOut <= dIn;
          end else if (start) begin
            modeLat <= mode;
            count   <= startCnt;
            if (startCnt != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          dOut  <= shifted;
          count <= count - ONE_CNT;
          if (count == ONE_CNT) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8). Table-driven load/shift operations plus
// hand-written sequences for reset, priority and mid-operation corner cases.
// Per-cycle expectations are queued after each clock edge and compared on the
// following falling edge.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk;
  logic             nRst;
  logic             load;
  logic [WIDTH-1:0] dIn;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] shAmt;
  logic             sInL;
  logic             sInR;
  logic [WIDTH-1:0] dOut;
  logic             sOutL;
  logic             sOutR;
  logic             busy;
  logic             done;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic       expBusy;
    logic       expDone;
    logic [7:0] expDout;
    string      name;
  } exp_t;

  exp_t expQ[$];

  typedef struct {
    string      name;
    logic [7:0] loadVal;
    logic [1:0] mode;
    logic [3:0] shAmt;
    logic       sInL;
    logic       sInR;
    logic [7:0] expFinal;
  } vec_t;

  vec_t vecs [0:8];

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .nRst  (nRst),
    .load  (load),
    .dIn   (dIn),
    .start (start),
    .mode  (mode),
    .shAmt (shAmt),
    .sInL  (sInL),
    .sInR  (sInR),
    .dOut  (dOut),
    .sOutL (sOutL),
    .sOutR (sOutR),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  // Reference single step for one shift/rotate position.
  function automatic logic [7:0] modelStep(input logic [7:0] v, input logic [1:0] m,
                                           input logic sl, input logic sr);
    case (m)
      2'b00:   return {v[6:0], sr};
`ifdef ARITH_SHIFT_EN
      2'b01:   return {v[7], v[7:1]};
`else
      2'b01:   return {sl, v[7:1]};
`endif
      2'b10:   return {v[6:0], v[7]};
      default: return {v[0], v[7:1]};
    endcase
  endfunction

  // Advance one clock and queue what the DUT should show during that cycle.
  task automatic tick(input logic b, input logic d, input logic [7:0] q, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.expBusy = b;
    e.expDone = d;
    e.expDout = q;
    e.name    = nm;
    expQ.push_back(e);
  endtask

  // Scoreboard: pop one expectation per cycle and compare away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.name, " dOut"},  dOut,         e.expDout);
      checkOutput({e.name, " busy"},  {7'd0, busy}, {7'd0, e.expBusy});
      checkOutput({e.name, " done"},  {7'd0, done}, {7'd0, e.expDone});
      checkOutput({e.name, " sOutL"}, {7'd0, sOutL}, {7'd0, e.expDout[7]});
      checkOutput({e.name, " sOutR"}, {7'd0, sOutR}, {7'd0, e.expDout[0]});
    end
  end

  // Load a value, run one operation and queue every cycle until back in IDLE.
  task automatic applyStimulus(input vec_t v);
    logic [7:0] cur;
    int n;
    load = 1'b1;
    dIn  = v.loadVal;
    tick(1'b0, 1'b0, v.loadVal, {v.name, " load"});
    load  = 1'b0;
    start = 1'b1;
    mode  = v.mode;
    shAmt = v.shAmt;
    sInL  = v.sInL;
    sInR  = v.sInR;
    n = (int'(v.shAmt) > WIDTH) ? WIDTH : int'(v.shAmt);
    cur = v.loadVal;
    if (n == 0) begin
      tick(1'b0, 1'b1, v.expFinal, {v.name, " zero"});
      start = 1'b0;
    end else begin
      tick(1'b1, 1'b0, cur, {v.name, " start"});
      start = 1'b0;
      for (int k = 1; k <= n; k++) begin
        cur = modelStep(cur, v.mode, v.sInL, v.sInR);
        if (k < n) tick(1'b1, 1'b0, cur, $sformatf("%s step%0d", v.name, k));
        else       tick(1'b0, 1'b1, v.expFinal, {v.name, " done"});
      end
    end
    tick(1'b0, 1'b0, v.expFinal, {v.name, " idle"});
  endtask

  initial begin
    vecs[0] = '{"rol3",   8'hA5, 2'b10, 4'd3,  1'b0, 1'b0, 8'h2D};
    vecs[1] = '{"shl2",   8'h81, 2'b00, 4'd2,  1'b0, 1'b1, 8'h07};
    vecs[2] = '{"ror15",  8'h07, 2'b11, 4'd15, 1'b0, 1'b0, 8'h07};
`ifdef ARITH_SHIFT_EN
    vecs[3] = '{"shr2",   8'h90, 2'b01, 4'd2,  1'b0, 1'b0, 8'hE4};
    vecs[4] = '{"shr1",   8'h3C, 2'b01, 4'd1,  1'b1, 1'b0, 8'h1E};
    vecs[7] = '{"shr9",   8'h00, 2'b01, 4'd9,  1'b1, 1'b0, 8'h00};
`else
    vecs[3] = '{"shr2",   8'h90, 2'b01, 4'd2,  1'b0, 1'b0, 8'h24};
    vecs[4] = '{"shr1",   8'h3C, 2'b01, 4'd1,  1'b1, 1'b0, 8'h9E};
    vecs[7] = '{"shr9",   8'h00, 2'b01, 4'd9,  1'b1, 1'b0, 8'hFF};
`endif
    vecs[5] = '{"amt0",   8'h5A, 2'b00, 4'd0,  1'b0, 1'b1, 8'h5A};
    vecs[6] = '{"rol8",   8'hC3, 2'b10, 4'd8,  1'b0, 1'b0, 8'hC3};
    vecs[8] = '{"shl9",   8'hFF, 2'b00, 4'd9,  1'b0, 1'b0, 8'h00};

    nRst = 1'b0; load = 1'b1; dIn = 8'hFF; start = 1'b0;
    mode = 2'b00; shAmt = '0; sInL = 1'b0; sInR = 1'b0;

    // Reset held while load is requested: register stays cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst dOut", dOut, 8'h00);
      checkOutput("rst busy", {7'd0, busy}, 8'h00);
      checkOutput("rst done", {7'd0, done}, 8'h00);
    end
    @(posedge clk);
    #1;
    nRst = 1'b1;
    dIn  = 8'hA5;
    tick(1'b0, 1'b0, 8'hA5, "rel load");
    load = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Load and start together: load wins, no operation begins.
    load = 1'b1; start = 1'b1; dIn = 8'h3C; mode = 2'b10; shAmt = 4'd3;
    tick(1'b0, 1'b0, 8'h3C, "ldst load");
    load = 1'b0; start = 1'b0;
    tick(1'b0, 1'b0, 8'h3C, "ldst idle1");
    tick(1'b0, 1'b0, 8'h3C, "ldst idle2");

    // Requests during DONE are dropped.
    load = 1'b1; dIn = 8'h81;
    tick(1'b0, 1'b0, 8'h81, "dn load");
    load = 1'b0; start = 1'b1; mode = 2'b10; shAmt = 4'd1;
    tick(1'b1, 1'b0, 8'h81, "dn start");
    start = 1'b0;
    tick(1'b0, 1'b1, 8'h03, "dn done");
    start = 1'b1; load = 1'b1; dIn = 8'hFF; shAmt = 4'd2;
    tick(1'b0, 1'b0, 8'h03, "dn ignored");
    start = 1'b0; load = 1'b0;
    tick(1'b0, 1'b0, 8'h03, "dn idle");

    // Mode/shAmt changes mid-shift have no effect; sInR is sampled live.
    load = 1'b1; dIn = 8'h00;
    tick(1'b0, 1'b0, 8'h00, "live load");
    load = 1'b0; start = 1'b1; mode = 2'b00; shAmt = 4'd3; sInR = 1'b1;
    tick(1'b1, 1'b0, 8'h00, "live start");
    start = 1'b0; mode = 2'b11; shAmt = 4'd0;
    tick(1'b1, 1'b0, 8'h01, "live s1");
    sInR = 1'b0;
    tick(1'b1, 1'b0, 8'h02, "live s2");
    sInR = 1'b1;
    tick(1'b0, 1'b1, 8'h05, "live done");
    tick(1'b0, 1'b0, 8'h05, "live idle");

    // Load pulse during a 5-step shift is ignored.
    load = 1'b1; dIn = 8'hA5; sInR = 1'b0;
    tick(1'b0, 1'b0, 8'hA5, "mid load");
    load = 1'b0; start = 1'b1; mode = 2'b00; shAmt = 4'd5;
    tick(1'b1, 1'b0, 8'hA5, "mid start");
    start = 1'b0;
    tick(1'b1, 1'b0, 8'h4A, "mid s1");
    load = 1'b1; dIn = 8'hFF;
    tick(1'b1, 1'b0, 8'h94, "mid s2");
    load = 1'b0;
    tick(1'b1, 1'b0, 8'h28, "mid s3");
    tick(1'b1, 1'b0, 8'h50, "mid s4");
    tick(1'b0, 1'b1, 8'hA0, "mid done");
    tick(1'b0, 1'b0, 8'hA0, "mid idle");

    // Asynchronous reset at step 3 aborts with no completion pulse.
    load = 1'b1; dIn = 8'hA5;
    tick(1'b0, 1'b0, 8'hA5, "abort load");
    load = 1'b0; start = 1'b1; shAmt = 4'd5;
    tick(1'b1, 1'b0, 8'hA5, "abort start");
    start = 1'b0;
    tick(1'b1, 1'b0, 8'h4A, "abort s1");
    tick(1'b1, 1'b0, 8'h94, "abort s2");
    tick(1'b1, 1'b0, 8'h28, "abort s3");
    @(negedge clk);
    #2;
    nRst = 1'b0;
    #1;
    checkOutput("async dOut", dOut, 8'h00);
    checkOutput("async busy", {7'd0, busy}, 8'h00);
    checkOutput("async done", {7'd0, done}, 8'h00);
    tick(1'b0, 1'b0, 8'h00, "abort held");
    nRst = 1'b1;
    tick(1'b0, 1'b0, 8'h00, "abort after1");
    tick(1'b0, 1'b0, 8'h00, "abort after2");
    tick(1'b0, 1'b0, 8'h00, "abort after3");

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard drain: %0d left, expected 0", expQ.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. Successor to the fixed 4-bit parallel-in/parallel-out register.
- Adds configurable width, serial in/out on both ends, and four shift/rotate modes.
- Adds a multi-position shift operation with busy/done handshake.
- Used as the general-purpose shifter in lab datapaths: parallel load, then shift by N under FSM control.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, width of shAmt and the internal shift counter

Ports:
clk  input  1  rising-edge clock
nRst  input  1  asynchronous active-low reset
load  input  1  parallel load request (honoured in IDLE only)
dIn  input  WIDTH  parallel load data
start  input  1  begin shift operation (honoured in IDLE only)
mode  input  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right
shAmt  input  CNT_W  number of positions to shift
sInL  input  1  serial fill bit entering at MSB on right shift
sInR  input  1  serial fill bit entering at LSB on left shift
dOut  output  WIDTH  register contents
sOutL  output  1  dOut[WIDTH-1], combinational
sOutR  output  1  dOut[0], combinational
busy  output  1  high while in SHIFT state
done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Reset: nRst low clears dOut=0, busy=0, done=0, counter=0, latched mode=0, state=IDLE immediately, regardless of clk. Reset mid-operation aborts the shift with no completion pulse.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE).
- IDLE, load=1:
  - dOut <= dIn on the edge.
  - load has priority over start when both are high in the same cycle; start is then ignored (no operation begins).
- IDLE, start=1, load=0:
  - Latch mode.
  - Latch count = min(shAmt, WIDTH); values above WIDTH clamp to WIDTH.
  - count>0 -> SHIFT; count==0 -> DONE directly, dOut unchanged.
  - No shift happens on the start edge.
- SHIFT: one position per edge using the latched mode; count decrements.
  - The edge that shifts with count==1 moves to DONE.
  - N-position op: start edge, N shift edges; done high the cycle after the Nth shift. busy is high for exactly N cycles.
- DONE: lasts one cycle, then IDLE unconditionally. load/start in DONE are ignored.
- Shift rules (one step):
  - 00 shift left: {dOut[WIDTH-2:0], sInR}
  - 01 shift right: {sInL, dOut[WIDTH-1:1]}
  - 10 rotate left: {dOut[WIDTH-2:0], dOut[WIDTH-1]}
  - 11 rotate right: {dOut[0], dOut[WIDTH-1:1]}
- sInL/sInR are sampled live on every shift edge (not latched at start). mode and shAmt changes during SHIFT have no effect.
- load/start during SHIFT or DONE are ignored; no queueing.
- Rotate by WIDTH returns the original value.

Optional Feature:
Macro ARITH_SHIFT_EN.
- Defined: mode 01 is an arithmetic right shift. Fill bit = dOut[WIDTH-1]; sInL is ignored.
- Undefined: mode 01 is a logical right shift filled from sInL.
- All other modes are identical in both builds.

Test Plan:
- WIDTH=8. Hold nRst=0 with load=1, dIn=8'hFF toggling clk -> dOut=00, busy=0, done=0. Release, load 8'hA5 -> dOut=A5 after next edge.
- dOut=A5, mode=10, shAmt=3, start=1 one cycle -> busy high 3 cycles, dOut 4B, 96, 2D, then done=1 for one cycle with dOut=2D.
- dOut=81, mode=00, sInR=1, shAmt=2 -> dOut 03 then 07, done pulse. Then mode=11, shAmt=15 -> clamped to 8, busy 8 cycles, final dOut=07.
- shAmt=0 with start -> done one cycle after start, busy never high, dOut unchanged. load=1 with start=1 in IDLE, dIn=3C -> dOut=3C, no busy, no done.
- During a 5-step shift: pulse load=1 with dIn=FF at step 2 -> ignored, shift completes normally. Assert nRst=0 at step 3 -> dOut=00, busy=0 immediately, no done pulse afterwards.
- dOut=90, mode=01, sInL=0, shAmt=2 -> ARITH_SHIFT_EN defined: C8 then E4. Undefined: 48 then 24.
